tpu_seq_loader: RTL and testbench
=================================

// Module: tpu_seq_loader
// PURPOSE
//  Upstream sequencer for the TPU core's memory-mapped port (r_w/addr/dataIn/dataOut).
//  - Accepts one matrix job as a stream of DATAW-bit words and writes it into A, B and C.
//  - Triggers the computation, waits it out, then streams the 2*DIM C half-rows back out.
//  - Sits between the host/AFU buffers and the TPU core; it is the only master of that port.
// PARAMETERS
//  DIM       8          systolic dimension (rows of A/B/C)
//  ADDRW     16         TPU address width
//  DATAW     64         TPU data word width (one A/B row, or one C half-row)
//  WAIT_CYC  3*DIM+2    idle cycles after GO before C is read; must be >= 3*DIM
// PORTS
//  clk        in   1      single clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      1-cycle job request; sampled only in IDLE
//  acc_en     in   1      sampled with start: 1 = load C from stream, 0 = write zeros to C
//  in_valid   in   1      input stream word valid
//  in_ready   out  1      input stream word accepted when in_valid&&in_ready
//  in_data    in   DATAW  input word: DIM A rows, then DIM B rows, then 2*DIM C half-rows (if acc_en)
//  out_valid  out  1      result word valid; held until out_ready
//  out_ready  in   1      downstream accepts result word
//  out_data   out  DATAW  C half-row: row0 low, row0 high, row1 low, ... row DIM-1 high
//  busy       out  1      high from accepted start until done
//  done       out  1      1-cycle pulse after last result word is accepted
//  tpu_r_w    out  1      to TPU: 1 = write, 0 = read
//  tpu_addr   out  ADDRW  to TPU address
//  tpu_din    out  DATAW  to TPU dataIn
//  tpu_dout   in   DATAW  from TPU dataOut (registered there: valid 1 cycle after read addr)
// BEHAVIOUR
//  Reset (sync, rst=1): state IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0,
//   tpu_r_w=0, tpu_addr=0, tpu_din=0; all counters 0. Mid-job reset aborts immediately;
//   the TPU core must be reset in the same cycle.
//  All outputs are registered. Idle bus value: r_w=0, addr=0 (a harmless read).
//  FSM states: IDLE, LD_A, LD_B, LD_C, ZR_C, GO, WAIT, RD_ADDR, RD_CAP, RD_OUT, FIN.
//  - IDLE: start=1 -> latch acc_en, busy<=1, LD_A. start while busy is ignored.
//  - LD_A: in_ready=1; each accepted word k -> write addr A_BASE+8*k. After k=DIM-1 -> LD_B.
//  - LD_B: same into B_BASE+8*k; order is preserved (B is shift-loaded in the core).
//    After DIM words -> LD_C if acc_en, else ZR_C.
//  - LD_C: 2*DIM words; word j -> C_BASE+16*(j>>1)+8*(j&1). Then -> GO.
//  - ZR_C: no input consumed; writes data 0 to the same 2*DIM C addresses, one per cycle.
//  - in_valid=0 in any LD state: bus idles that cycle and no counter advances.
//  - GO: one write to GO_ADDR (data 0) -> WAIT.
//  - WAIT: WAIT_CYC idle-bus cycles (down-counter) -> RD_ADDR.
//  - RD_ADDR: read addr for half-row j -> RD_CAP. RD_CAP: bus idle, capture tpu_dout into out_data,
//    out_valid<=1 -> RD_OUT.
//  - RD_OUT: hold until out_ready. Then j+1 -> RD_ADDR, or after j=2*DIM-1 -> FIN.
//    Result throughput is at most 1 word per 3 cycles.
//  - FIN: done<=1, busy<=0 -> IDLE.
//  Word counters are $clog2(2*DIM)+1 bits and never wrap within a job.
//  The core never sees a write while it is computing (WAIT guarantees it).
// STRUCTURE
//  tpu_pkg: A_BASE=16'h100, B_BASE=16'h200, C_BASE=16'h300, GO_ADDR=16'h400,
//   and the seq_state_t enum; shared with the TPU core and the bench.
//  Single module; no sub-modules. The read path (RD_ADDR/RD_CAP/RD_OUT) is kept in the same FSM.
// TESTING
//  T1 reset: rst high 2 cycles mid-LD_B -> all outputs 0 next cycle, IDLE, next start runs full job.
//  T2 identity: A=I, B rows=k+1 in every byte, acc_en=0, in_valid constant
//   -> out_data words equal C=A*B. Check addr trace 0x100..0x138, 0x200..0x238,
//   0x300..0x378 (step 8), 0x400.
//  T3 accumulate: same as T2 with acc_en=1 and C half-rows all 16'h0001 -> every C element +1.
//  T4 input stalls: in_valid toggled 1/0 -> identical results; no write issued on stall cycles.
//  T5 output backpressure: out_ready low 5 cycles per word -> out_data stable while out_valid=1,
//   16 words, then done pulses exactly once.
//  T6 start ignored: start pulsed during WAIT and RD_OUT -> no effect; job still has 16 outputs.

Source files
------------

// File: rtl/tpu_pkg.sv
// Address map and sequencer state encoding shared by the TPU core, its loader and the bench.
package tpu_pkg;

  localparam logic [15:0] A_BASE  = 16'h0100;
  localparam logic [15:0] B_BASE  = 16'h0200;
  localparam logic [15:0] C_BASE  = 16'h0300;
  localparam logic [15:0] GO_ADDR = 16'h0400;

  typedef enum logic [3:0] {
    IDLE,
    LD_A,
    LD_B,
    LD_C,
    ZR_C,
    GO,
    WAIT,
    RD_ADDR,
    RD_CAP,
    RD_OUT,
    FIN
  } seq_state_t;

  // Every A/B row and C half-row occupies one 8-byte slot above its base.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {5'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/tpu_seq_loader.sv
// Sole master of the TPU core port: streams a job into A/B/C, fires GO, waits, streams C back.
// All outputs registered; input stalls idle the bus, result words held until out_ready (1 word / 3 cycles max).
module tpu_seq_loader
  import tpu_pkg::*;
#(
  parameter int DIM      = 8,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int WAIT_CYC = 3*DIM+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_din,
  input  logic [DATAW-1:0] tpu_dout
);

  localparam int CNTW = $clog2(2*DIM) + 1;
  localparam int WCW  = $clog2(WAIT_CYC + 1);
  localparam logic [CNTW-1:0] ROW_LAST  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(2*DIM - 1);

  seq_state_t       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             r_w_q, r_w_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] din_q, din_d;
  logic             in_acc;

  function automatic logic [ADDRW-1:0] slot_addr(input logic [15:0] base, input logic [CNTW-1:0] idx);
    return ADDRW'(word_addr(base, 8'(idx)));
  endfunction

  assign in_acc = in_valid && in_ready_q;

  // Bus fields computed here appear on the port next cycle, so a read address is
  // issued on entry to RD_ADDR and the core's registered data is ready in RD_CAP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    r_w_d       = 1'b0;
    addr_d      = '0;
    din_d       = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = acc_en;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = LD_A;
        end
      end

      LD_A: begin
        if (in_acc) begin
          r_w_d  = 1'b1;
          addr_d = slot_addr(A_BASE, cnt_q);
          din_d  = in_data;
          if (cnt_q == ROW_LAST) begin
            cnt_d   = '0;
            state_d = LD_B;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      LD_B: begin
        if (in_acc) begin
          r_w_d  = 1'b1;
          addr_d = slot_addr(B_BASE, cnt_q);
          din_d  = in_data;
          if (cnt_q == ROW_LAST) begin
            cnt_d   = '0;
            state_d = acc_q ? LD_C : ZR_C;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      LD_C: begin
        if (in_acc) begin
          r_w_d  = 1'b1;
          addr_d = slot_addr(C_BASE, cnt_q);
          din_d  = in_data;
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            state_d = GO;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      ZR_C: begin
        r_w_d  = 1'b1;
        addr_d = slot_addr(C_BASE, cnt_q);
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = GO;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      GO: begin
        r_w_d   = 1'b1;
        addr_d  = ADDRW'(GO_ADDR);
        wait_d  = WCW'(WAIT_CYC);
        state_d = WAIT;
      end

      // First WAIT cycle carries the GO write; WAIT_CYC idle cycles follow it.
      WAIT: begin
        if (wait_q == '0) begin
          addr_d  = slot_addr(C_BASE, cnt_q);
          state_d = RD_ADDR;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end

      RD_ADDR: state_d = RD_CAP;

      RD_CAP: begin
        out_data_d  = tpu_dout;
        out_valid_d = 1'b1;
        state_d     = RD_OUT;
      end

      RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d   = cnt_q + CNTW'(1);
            addr_d  = slot_addr(C_BASE, cnt_q + CNTW'(1));
            state_d = RD_ADDR;
          end
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LD_A) || (state_d == LD_B) || (state_d == LD_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      acc_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      r_w_q       <= r_w_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tpu_r_w   = r_w_q;
  assign tpu_addr  = addr_q;
  assign tpu_din   = din_q;

endmodule

// File: tb/tb_tpu_seq_loader.sv
// Directed bench for tpu_seq_loader with a behavioural TPU core model on the memory port.
module tb_tpu_seq_loader;
  import tpu_pkg::*;

  localparam int DIM      = 8;
  localparam int WAIT_CYC = 3*DIM + 2;

  logic        clk = 1'b0;
  logic        rst, start, acc_en, in_valid, in_ready, out_valid, out_ready, busy, done, tpu_r_w;
  logic [63:0] in_data, out_data, tpu_din, tpu_dout;
  logic [15:0] tpu_addr;

  always #5 clk = ~clk;

  tpu_seq_loader #(.DIM(DIM), .ADDRW(16), .DATAW(64), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_din(tpu_din), .tpu_dout(tpu_dout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- TPU core model: 8-bit A/B elements, 16-bit C elements, C += A*B on GO ----
  logic [DIM-1:0][63:0]   a_arr, b_arr;
  logic [2*DIM-1:0][63:0] c_arr;
  logic [15:0] wr_addr_q[$];
  logic [63:0] wr_dat_q[$];
  int  gap_cnt = 0;
  int  last_gap = 0;
  int  wr_in_compute = 0;
  bit  computing = 1'b0;

  function automatic logic [2*DIM-1:0][63:0] matmul(input logic [DIM-1:0][63:0] a,
                                                     input logic [DIM-1:0][63:0] b,
                                                     input logic [2*DIM-1:0][63:0] c);
    logic [2*DIM-1:0][63:0] r;
    logic [15:0] acc;
    r = c;
    for (int row = 0; row < DIM; row++) begin
      for (int col = 0; col < DIM; col++) begin
        acc = r[2*row + col/4][16*(col%4) +: 16];
        for (int k = 0; k < DIM; k++)
          acc = acc + 16'(a[row][8*k +: 8]) * 16'(b[k][8*col +: 8]);
        r[2*row + col/4][16*(col%4) +: 16] = acc;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      tpu_dout  <= 64'h0;
      computing <= 1'b0;
    end else if (tpu_r_w) begin
      wr_addr_q.push_back(tpu_addr);
      wr_dat_q.push_back(tpu_din);
      if (computing) wr_in_compute <= wr_in_compute + 1;
      case (tpu_addr[15:8])
        8'h01:   a_arr[tpu_addr[5:3]] <= tpu_din;
        8'h02:   b_arr[tpu_addr[5:3]] <= tpu_din;
        8'h03:   c_arr[tpu_addr[6:3]] <= tpu_din;
        8'h04: begin
          c_arr     <= matmul(a_arr, b_arr, c_arr);
          computing <= 1'b1;
          gap_cnt   <= 0;
        end
        default: ;
      endcase
    end else begin
      tpu_dout <= (tpu_addr[15:8] == 8'h03) ? c_arr[tpu_addr[6:3]] : 64'h0;
      if (computing) begin
        if (tpu_addr == 16'h0300) begin
          computing <= 1'b0;
          last_gap  <= gap_cnt;
        end else if (tpu_addr == 16'h0000) begin
          gap_cnt <= gap_cnt + 1;
        end
      end
    end
  end

  // ---- stimulus helpers ----
  function automatic logic [63:0] a_row(input int k);
    logic [63:0] one;
    one = 64'h1;
    return one << (8*k);
  endfunction

  function automatic logic [63:0] b_row(input int k);
    return {8{8'(k + 1)}};
  endfunction

  localparam logic [63:0] C_ONES = 64'h0001_0001_0001_0001;

  task automatic check_idle(input string pfx);
    check({pfx, "_in_ready"},  {63'h0, in_ready},  64'h0);
    check({pfx, "_out_valid"}, {63'h0, out_valid}, 64'h0);
    check({pfx, "_out_data"},  out_data,           64'h0);
    check({pfx, "_busy"},      {63'h0, busy},      64'h0);
    check({pfx, "_done"},      {63'h0, done},      64'h0);
    check({pfx, "_tpu_r_w"},   {63'h0, tpu_r_w},   64'h0);
    check({pfx, "_tpu_addr"},  {48'h0, tpu_addr},  64'h0);
    check({pfx, "_tpu_din"},   tpu_din,            64'h0);
  endtask

  task automatic push(input logic [63:0] w, input bit stall);
    int guard;
    guard = 0;
    if (stall) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit acc);
    start  = 1'b1;
    acc_en = acc;
    @(posedge clk); #1;
    start  = 1'b0;
    acc_en = 1'b0;
  endtask

  task automatic collect(input string tn, input bit acc, input int bp, input bit glitch);
    logic [63:0] exp;
    int guard, dn;
    bit ok;
    for (int j = 0; j < 2*DIM; j++) begin
      exp   = {4{16'((j >> 1) + 1 + int'(acc))}};
      guard = 0;
      ok    = 1'b1;
      while (!out_valid && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!out_valid) check($sformatf("%s_out_valid_timeout[%0d]", tn, j), 64'h0, 64'h1);
      for (int b = 0; b < bp; b++) begin
        if (!(out_valid === 1'b1 && out_data === exp)) ok = 1'b0;
        if (glitch && j == 3 && b == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (bp > 0) check($sformatf("%s_out_hold[%0d]", tn, j), {63'h0, ok}, 64'h1);
      check($sformatf("%s_out_data[%0d]", tn, j), out_data, exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      @(posedge clk); #1;
    end
    check({tn, "_done_pulses"}, 64'(dn), 64'd1);
    check({tn, "_busy_after"}, {63'h0, busy}, 64'h0);
    if (glitch) check({tn, "_no_restart"}, {62'h0, in_ready, busy}, 64'h0);
  endtask

  task automatic run_job(input string tn, input bit acc, input bit stall, input int bp, input bit glitch);
    int t0, n, bad_a, bad_d;
    logic [15:0] ea;
    logic [63:0] ed;
    t0 = wr_addr_q.size();
    pulse_start(acc);
    check({tn, "_busy_on_start"}, {63'h0, busy}, 64'h1);
    for (int k = 0; k < DIM; k++) push(a_row(k), stall);
    for (int k = 0; k < DIM; k++) push(b_row(k), stall);
    if (acc) for (int j = 0; j < 2*DIM; j++) push(C_ONES, stall);
    if (glitch) begin
      repeat (acc ? 6 : 22) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    collect(tn, acc, bp, glitch);

    n = wr_addr_q.size() - t0;
    check({tn, "_wr_count"}, 64'(n), 64'd33);
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < n && i < 33; i++) begin
      if (i < 8) begin
        ea = 16'(16'h100 + 8*i);      ed = a_row(i);
      end else if (i < 16) begin
        ea = 16'(16'h200 + 8*(i-8));  ed = b_row(i-8);
      end else if (i < 32) begin
        ea = 16'(16'h300 + 8*(i-16)); ed = acc ? C_ONES : 64'h0;
      end else begin
        ea = 16'h400;                 ed = 64'h0;
      end
      if (wr_addr_q[t0+i] !== ea) bad_a++;
      if (wr_dat_q[t0+i] !== ed) bad_d++;
    end
    check({tn, "_wr_addr_trace"}, 64'(bad_a), 64'd0);
    check({tn, "_wr_data_trace"}, 64'(bad_d), 64'd0);
    check({tn, "_wait_idle_cycles"}, 64'(last_gap), 64'(WAIT_CYC));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no $finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; acc_en = 1'b0;
    in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: reset in the middle of loading B
    pulse_start(1'b0);
    for (int k = 0; k < DIM; k++) push(a_row(k), 1'b0);
    for (int k = 0; k < 3; k++) push(b_row(k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("t1_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("t1_after");

    run_job("t2_ident",  1'b0, 1'b0, 0, 1'b0);
    run_job("t3_accum",  1'b1, 1'b0, 0, 1'b0);
    run_job("t4_stall",  1'b0, 1'b1, 0, 1'b0);
    run_job("t5_bp",     1'b0, 1'b0, 5, 1'b0);
    run_job("t6_glitch", 1'b0, 1'b0, 2, 1'b1);

    check("wr_during_compute", 64'(wr_in_compute), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
